// File: rtl/fp24_to_fixed.sv
// fp24 (sign, 7b exponent bias 63, 16b mantissa with hidden 1) to signed fixed-point converter.
// Three-stage elastic pipeline; rounds half away from zero and saturates to the output range.
module fp24_to_fixed #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [23:0]      in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_n,
   output logic             out_sat,
   output logic             out_uflow
);

   localparam int unsigned       WideW  = WIDTH + 17;
   localparam logic signed [8:0] EOff   = 9'(int'(FRAC) - 79);
   localparam logic signed [8:0] OvfE   = 9'(int'(WIDTH) - 16);
   localparam logic signed [8:0] MinE   = -9'sd17;
   localparam logic [WIDTH:0]    MaxPos = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH:0]    NegLim = {2'b01, {(WIDTH-1){1'b0}}};

   logic v1_q, v2_q, v3_q;
   logic ready1, ready2, ready3;

   logic                s1_sign_q, s1_zero_q;
   logic [16:0]         s1_m_q;
   logic signed [8:0]   s1_e_q;
   logic signed [8:0]   s1_e_d;

   logic                s2_sign_q, s2_zero_q, s2_ovf_q;
   logic [WIDTH:0]      s2_mag_q;
   logic [WIDTH:0]      s2_mag_d;
   logic                s2_ovf_d;
   logic [WideW-1:0]    wide;
   logic [16:0]         rsh;
   logic [8:0]          e_inv;
   logic                ovf_e;

   logic [WIDTH-1:0]    n_q, n_d;
   logic                sat_q, sat_d, uflow_q, uflow_d;
   logic [WIDTH:0]      neg_mag;

   // Ready ripples back from the consumer so a full pipe still moves every cycle.
   assign ready3   = !v3_q || out_ready;
   assign ready2   = !v2_q || ready3;
   assign ready1   = !v1_q || ready2;
   assign in_ready = ready1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         if (ready1) v1_q <= in_valid;
         if (ready2) v2_q <= v1_q;
         if (ready3) v3_q <= v2_q;
      end
   end

   // S1: unpack and compute the net binary exponent of the scaled magnitude.
   assign s1_e_d = $signed({2'b00, in_x[22:16]}) + EOff;

   always_ff @(posedge clk) begin
      if (in_valid && ready1) begin
         s1_sign_q <= in_x[23];
         s1_zero_q <= (in_x[22:16] == 7'd0);
         s1_m_q    <= {1'b1, in_x[15:0]};
         s1_e_q    <= s1_e_d;
      end
   end

   // S2: align the mantissa; right shifts round on the last bit shifted out.
   always_comb begin
      wide  = '0;
      rsh   = '0;
      e_inv = ~s1_e_q;
      ovf_e = 1'b0;
      if (!s1_zero_q) begin
         if (!s1_e_q[8]) begin
            wide  = {{WIDTH{1'b0}}, s1_m_q} << s1_e_q[6:0];
            ovf_e = (s1_e_q > OvfE);
         end else if (s1_e_q >= MinE) begin
            rsh  = s1_m_q >> e_inv[4:0];
            wide = WideW'(rsh[16:1]) + WideW'(rsh[0]);
         end
      end
      s2_mag_d = wide[WIDTH:0];
      s2_ovf_d = ovf_e | (|wide[WideW-1:WIDTH+1]);
   end

   always_ff @(posedge clk) begin
      if (v1_q && ready2) begin
         s2_sign_q <= s1_sign_q;
         s2_zero_q <= s1_zero_q;
         s2_mag_q  <= s2_mag_d;
         s2_ovf_q  <= s2_ovf_d;
      end
   end

   // S3: apply sign and clamp; the most negative code is reachable without saturation.
   always_comb begin
      neg_mag = -s2_mag_q;
      sat_d   = 1'b0;
      n_d     = s2_mag_q[WIDTH-1:0];
      if (s2_sign_q) begin
         n_d = neg_mag[WIDTH-1:0];
         if (s2_ovf_q || (s2_mag_q > NegLim)) begin
            sat_d = 1'b1;
            n_d   = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end else if (s2_ovf_q || (s2_mag_q > MaxPos)) begin
         sat_d = 1'b1;
         n_d   = {1'b0, {(WIDTH-1){1'b1}}};
      end
      uflow_d = !s2_zero_q && !s2_ovf_q && (s2_mag_q == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q     <= '0;
         sat_q   <= 1'b0;
         uflow_q <= 1'b0;
      end else if (v2_q && ready3) begin
         n_q     <= n_d;
         sat_q   <= sat_d;
         uflow_q <= uflow_d;
      end
   end

   assign out_valid = v3_q;
   assign out_n     = n_q;
   assign out_sat   = sat_q;
   assign out_uflow = uflow_q;

endmodule

// File: tb/tb_fp24_to_fixed.sv
// Self-checking bench for fp24_to_fixed (WIDTH=16, FRAC=8): directed vectors, streaming,
// random stalls against an arithmetic reference model, and mid-stream reset.
module tb_fp24_to_fixed;

   localparam int W = 16;
   localparam int F = 8;

   // {x, expected n, sat, uflow}
   localparam logic [41:0] DIR [14] = '{
      {24'h3F0000, 16'h0100, 1'b0, 1'b0},
      {24'hBF8000, 16'hFE80, 1'b0, 1'b0},
      {24'h000000, 16'h0000, 1'b0, 1'b0},
      {24'h800000, 16'h0000, 1'b0, 1'b0},
      {24'h360000, 16'h0001, 1'b0, 1'b0},
      {24'h350000, 16'h0000, 1'b0, 1'b1},
      {24'h36FFFF, 16'h0001, 1'b0, 1'b0},
      {24'h3F4001, 16'h0140, 1'b0, 1'b0},
      {24'hBF4080, 16'hFEBF, 1'b0, 1'b0},
      {24'h460000, 16'h7FFF, 1'b1, 1'b0},
      {24'hC60000, 16'h8000, 1'b0, 1'b0},
      {24'hC64000, 16'h8000, 1'b1, 1'b0},
      {24'h7F0000, 16'h7FFF, 1'b1, 1'b0},
      {24'h45FFFF, 16'h7FFF, 1'b1, 1'b0}
   };

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [23:0]   in_x = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_n;
   logic          out_sat;
   logic          out_uflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp24_to_fixed #(.WIDTH(W), .FRAC(F)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_n     (out_n),
      .out_sat   (out_sat),
      .out_uflow (out_uflow)
   );

   // Reference: value*2^F = M * 2^e, rounded half away from zero on the magnitude, then clamped.
   function automatic void model(input logic [23:0] x, output logic [W-1:0] n,
                                 output logic sat, output logic uf);
      longint m, mag, v, lo, hi;
      int e;
      n = '0; sat = 1'b0; uf = 1'b0;
      if (x[22:16] == 7'd0) return;
      m = 65536 + longint'(x[15:0]);
      e = int'(x[22:16]) - 63 + F - 16;
      if (e >= 0) mag = (e > 30) ? 64'h7FFF_FFFF_FFFF : (m << e);
      else if (e < -40) mag = 0;
      else mag = (m + (longint'(1) << (-e - 1))) >> (-e);
      v  = x[23] ? -mag : mag;
      lo = -(longint'(1) << (W - 1));
      hi = (longint'(1) << (W - 1)) - 1;
      if (v > hi) begin v = hi; sat = 1'b1; end
      if (v < lo) begin v = lo; sat = 1'b1; end
      n  = v[W-1:0];
      uf = (mag == 0);
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
      if (out_n !== '0) begin errors++; $display("FAIL rst_n got %h want 0000", out_n); end
      if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_sat got %b want 0", out_sat); end
      if (out_uflow !== 1'b0) begin errors++; $display("FAIL rst_uflow got %b want 0", out_uflow); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      @(posedge clk); #3 rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [41:0] vec;
      int lat;
      for (int i = 0; i < 14; i++) begin
         vec = DIR[i];
         @(posedge clk); #1;
         in_x = vec[41:18]; in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
         checks += 4;
         if (lat != 3) begin errors++; $display("FAIL dir_lat[%0d] got %0d want 3", i, lat); end
         if (out_n !== vec[17:2]) begin
            errors++; $display("FAIL dir_n[%0d] x=%h got %h want %h", i, vec[41:18], out_n, vec[17:2]);
         end
         if (out_sat !== vec[1]) begin
            errors++; $display("FAIL dir_sat[%0d] x=%h got %b want %b", i, vec[41:18], out_sat, vec[1]);
         end
         if (out_uflow !== vec[0]) begin
            errors++; $display("FAIL dir_uflow[%0d] x=%h got %b want %b", i, vec[41:18], out_uflow, vec[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [41:0] vec;
      logic exp_v;
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         if (j < 4) begin vec = DIR[j]; in_x = vec[41:18]; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(negedge clk);
         exp_v = (j >= 3) && (j <= 6);
         checks++;
         if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", j, out_valid, exp_v); end
         if (exp_v) begin
            vec = DIR[j-3];
            checks += 2;
            if (out_n !== vec[17:2]) begin errors++; $display("FAIL b2b_n[%0d] got %h want %h", j, out_n, vec[17:2]); end
            if ({out_sat, out_uflow} !== 2'b00) begin
               errors++; $display("FAIL b2b_flags[%0d] got %b%b want 00", j, out_sat, out_uflow);
            end
         end
      end
   endtask

   task automatic test_random_stall();
      logic [23:0]  wq [20];
      logic [W-1:0] en [20];
      logic         es [20], eu [20];
      logic [6:0]   ex;
      logic         in_hs, out_hs, stall_prev, exp_rdy, last_sat, last_uf;
      logic [W-1:0] last_n;
      int ii, oi, inflight, cyc;
      for (int i = 0; i < 20; i++) begin
         ex = ($urandom % 8 == 0) ? 7'd0 : 7'($urandom_range(45, 80));
         wq[i] = {1'($urandom % 2), ex, 16'($urandom)};
         model(wq[i], en[i], es[i], eu[i]);
      end
      ii = 0; oi = 0; inflight = 0; cyc = 0;
      in_hs = 1'b0; stall_prev = 1'b0; last_n = '0; last_sat = 1'b0; last_uf = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (oi < 20 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         if (in_hs) ii++;
         if (!(in_valid && !in_hs)) begin
            if (ii < 20) begin in_valid = ($urandom % 4 != 0); in_x = wq[ii]; end
            else in_valid = 1'b0;
         end
         out_ready = ($urandom % 3 != 0);
         @(negedge clk);
         in_hs  = in_valid && in_ready;
         out_hs = out_valid && out_ready;
         exp_rdy = !(inflight == 3 && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy);
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_n !== last_n || out_sat !== last_sat || out_uflow !== last_uf) begin
               errors++;
               $display("FAIL rnd_stall cyc %0d got v=%b n=%h s=%b u=%b want v=1 n=%h s=%b u=%b",
                        cyc, out_valid, out_n, out_sat, out_uflow, last_n, last_sat, last_uf);
            end
         end
         if (out_hs) begin
            checks++;
            if (oi >= 20) begin
               errors++; $display("FAIL rnd_extra got n=%h want no word", out_n);
            end else if (out_n !== en[oi] || out_sat !== es[oi] || out_uflow !== eu[oi]) begin
               errors++;
               $display("FAIL rnd_word[%0d] x=%h got n=%h s=%b u=%b want n=%h s=%b u=%b",
                        oi, wq[oi], out_n, out_sat, out_uflow, en[oi], es[oi], eu[oi]);
            end
            oi++;
         end
         inflight += int'(in_hs) - int'(out_hs);
         stall_prev = out_valid && !out_ready;
         last_n = out_n; last_sat = out_sat; last_uf = out_uflow;
      end
      checks++;
      if (oi < 20) begin errors++; $display("FAIL rnd_timeout got %0d words want 20", oi); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_dup[%0d] got valid=%b want 0", k, out_valid); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midstream();
      logic [W-1:0] en;
      logic es, eu;
      logic [41:0] vec;
      int lat;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         vec = DIR[k + 7]; in_x = vec[41:18]; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      model(24'h3F4001, en, es, eu);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_full_valid got %b want 1", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mr_full_ready got %b want 0", in_ready); end
      if (out_n !== en) begin errors++; $display("FAIL mr_full_n got %h want %h", out_n, en); end
      #3 rst = 1'b0;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_async_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_hold_valid got %b want 0", out_valid); end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_post_valid got %b want 0", out_valid); end
      model(24'hC1A000, en, es, eu);
      in_x = 24'hC1A000; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      checks += 3;
      if (lat != 3) begin errors++; $display("FAIL mr_lat got %0d want 3", lat); end
      if (out_n !== en) begin errors++; $display("FAIL mr_n got %h want %h", out_n, en); end
      if ({out_sat, out_uflow} !== {es, eu}) begin
         errors++; $display("FAIL mr_flags got %b%b want %b%b", out_sat, out_uflow, es, eu);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random_stall();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
